// File: rtl/heap_array_unit.sv
// heap_array_unit: heap-memory array engine for WRITE / READ / RESIZE / SIZE / SHIFT_UP over NArrays areas.
// Optional overflow pulse on a full-array SHIFT_UP is built when HEAP_SHIFT_OVERFLOW_EN is defined.

module heap_array_unit #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea = 4,
    parameter int NArrays = 2,
    localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [AW-1:0]                 cmd_array,
    input  logic [MemoryElementWidth-1:0] cmd_index,
    input  logic [MemoryElementWidth-1:0] cmd_data,
    output logic                          rsp_valid,
    output logic [MemoryElementWidth-1:0] rsp_data,
    output logic                          rsp_error,
    output logic                          overflow
);

    localparam int W  = MemoryElementWidth;
    localparam int IW = (NArea > 1) ? $clog2(NArea) : 1;
    localparam logic [W-1:0] AREA    = W'(NArea);
    localparam logic [W-1:0] AREA_M1 = W'(NArea - 1);

    localparam logic [2:0] OP_WRITE    = 3'd0;
    localparam logic [2:0] OP_READ     = 3'd1;
    localparam logic [2:0] OP_RESIZE   = 3'd2;
    localparam logic [2:0] OP_SIZE     = 3'd3;
    localparam logic [2:0] OP_SHIFT_UP = 3'd4;

    typedef enum logic [1:0] {IDLE, SHIFT, INSERT, RESP} state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [AW-1:0] array_q;
    logic [W-1:0]  index_q;
    logic [W-1:0]  data_q;
    logic [IW-1:0] k_q;

    logic [W-1:0] mem  [NArrays][NArea];
    logic [W-1:0] size [NArrays];

    logic          cmd_array_ok;
    logic          array_ok;
    logic          index_ok;
    logic [W-1:0]  cmd_size;
    logic [W-1:0]  start_k;
    logic [W-1:0]  cur_size;
    logic [W-1:0]  elem;

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_val;
    logic          sz_en;
    logic [W-1:0]  sz_val;

    assign cmd_ready = (state == IDLE);

    // Array numbers at or above NArrays are only legal on the port, never as memory indices.
    always_comb begin
        cmd_array_ok = (int'(cmd_array) < NArrays);
        array_ok     = (int'(array_q) < NArrays);
        index_ok     = (index_q < AREA);
        cmd_size     = '0;
        cur_size     = '0;
        elem         = '0;
        if (cmd_array_ok) cmd_size = size[cmd_array];
        if (array_ok) cur_size = size[array_q];
        if (array_ok && index_ok) elem = mem[array_q][index_q[IW-1:0]];
        start_k = (cmd_size < AREA_M1) ? cmd_size : AREA_M1;
    end

    // Single element write port and single size write port, both targeting array_q.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = k_q;
        wr_val = data_q;
        sz_en  = 1'b0;
        sz_val = '0;
        case (state)
            SHIFT: begin
                wr_en  = 1'b1;
                wr_idx = k_q;
                wr_val = mem[array_q][k_q - IW'(1)];
            end
            INSERT: begin
                wr_en  = 1'b1;
                wr_idx = '0;
                wr_val = data_q;
                sz_en  = 1'b1;
                sz_val = (cur_size < AREA) ? cur_size + W'(1) : AREA;
            end
            RESP: begin
                if (op_q == OP_WRITE && array_ok && index_ok) begin
                    wr_en  = 1'b1;
                    wr_idx = index_q[IW-1:0];
                    wr_val = data_q;
                    if (cur_size <= index_q) begin
                        sz_en  = 1'b1;
                        sz_val = index_q + W'(1);
                    end
                end
                if (op_q == OP_RESIZE && array_ok) begin
                    sz_en  = 1'b1;
                    sz_val = (data_q > AREA) ? AREA : data_q;
                end
            end
            default: ;
        endcase
    end

    for (genvar a = 0; a < NArrays; a++) begin : g_array
        for (genvar e = 0; e < NArea; e++) begin : g_elem
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    mem[a][e] <= '0;
                else if (wr_en && array_q == AW'(a) && wr_idx == IW'(e))
                    mem[a][e] <= wr_val;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                size[a] <= '0;
            else if (sz_en && array_q == AW'(a))
                size[a] <= sz_val;
        end
    end

    // Shift count k counts down to 1; the k=1 edge moves element 0 up and hands over to INSERT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            array_q   <= '0;
            index_q   <= '0;
            data_q    <= '0;
            k_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        array_q <= cmd_array;
                        index_q <= cmd_index;
                        data_q  <= cmd_data;
                        k_q     <= start_k[IW-1:0];
                        if (cmd_op == OP_SHIFT_UP && cmd_array_ok)
                            state <= (start_k != '0) ? SHIFT : INSERT;
                        else
                            state <= RESP;
                    end
                end
                SHIFT: begin
                    k_q <= k_q - IW'(1);
                    if (k_q == IW'(1)) state <= INSERT;
                end
                INSERT: begin
                    state <= RESP;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    case (op_q)
                        OP_WRITE:    rsp_error <= !(array_ok && index_ok);
                        OP_READ: begin
                            if (array_ok && index_ok) rsp_data <= elem;
                            else rsp_error <= 1'b1;
                        end
                        OP_RESIZE:   rsp_error <= !array_ok || (data_q > AREA);
                        OP_SIZE: begin
                            if (array_ok) rsp_data <= cur_size;
                            else rsp_error <= 1'b1;
                        end
                        OP_SHIFT_UP: rsp_error <= !array_ok;
                        default:     rsp_error <= 1'b1;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HEAP_SHIFT_OVERFLOW_EN
    logic full_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (state == IDLE && cmd_valid)
                full_q <= cmd_array_ok && (cmd_size >= AREA);
            if (state == RESP && op_q == OP_SHIFT_UP && full_q)
                overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
